pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer for the CPU front end.
//  Drives the current PC to the 32-bit PC+4 adder and to instruction memory.
//  Takes the adder's sum back as the sequential next PC.
//  Applies jump/branch redirects, squashes the wrong-path fetch and delivers fetched
//  instructions to decode as one-cycle valid pulses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded during reset
//  EXC_VECTOR  32'h0000_0080  exception target (used only with PC_EXC_VECTOR_EN)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  pc             out  32  current PC; to adder input a (b tied 32'd4) and imem address
//  pc_plus4       in   32  adder sum p (pc+4), combinational from pc
//  jump_en        in   1   jump redirect request, 1-cycle pulse
//  jump_target    in   32  jump destination
//  branch_en      in   1   taken-branch redirect request, 1-cycle pulse
//  branch_target  in   32  branch destination
//  stall          in   1   decode not ready; blocks issue of new fetches
//  imem_req       out  1   fetch request; imem address = pc
//  imem_ack       in   1   memory accepted request, imem_rdata valid this cycle
//  imem_rdata     in   32  fetched instruction word
//  inst           out  32  last delivered instruction
//  inst_valid     out  1   1-cycle pulse: inst is new and on the correct path
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, imem_req=0, inst=0,
//   inst_valid=0, state=IDLE, redirect_pending=0, pending_target=0.
//  Reset mid-fetch abandons the outstanding request; imem_ack is ignored until REQ.
//  FSM, 2 states:
//   IDLE: imem_req=0. stall=0 -> REQ next cycle. stall=1 -> stay.
//   REQ: imem_req=1, held high until imem_ack (never retracted; stall ignored here).
//    On ack: pc<=next_pc; if stall=1 -> IDLE, else stay REQ (back-to-back fetch).
//  Delivery: on ack cycle N, inst<=imem_rdata at edge N.
//   inst_valid=1 during cycle N+1 only, unless squashed; inst holds value otherwise.
//  next_pc priority: jump_en > branch_en > redirect_pending > pc_plus4.
//  Redirect targets are aligned: bits [1:0] forced to 2'b00.
//  Redirect in IDLE: pc<=target at next edge; nothing is squashed.
//  Redirect in REQ without ack:
//   latch pending_target, set redirect_pending; a later redirect overwrites it.
//  On ack with redirect_pending or a same-cycle redirect:
//   fetched word is squashed (inst_valid stays 0, inst still updated).
//   pc<=target; redirect_pending cleared.
//  jump_en and branch_en in the same cycle: jump wins; branch dropped.
//  PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 (from adder), no flag.
//  Fetch latency: req to inst_valid is ack wait + 1 cycle.
//  Best-case throughput is 1 instruction/cycle (ack same cycle as req).
// CONFIGURATION
//  PC_EXC_VECTOR_EN defined:
//   adds ports exc_req (in,1) and epc (out,32; reset 0).
//   exc_req has priority above jump_en and is handled like a redirect to EXC_VECTOR.
//   epc<=pc in the exc_req cycle.
//  PC_EXC_VECTOR_EN undefined: exc_req/epc absent; EXC_VECTOR unused.
//   Behaviour identical to the text above.
// TESTING
//  Reset then release, ack every cycle, rdata=pc -> inst_valid pulses with inst
//   0,4,8,C on consecutive cycles.
//  Ack delayed 3 cycles at pc=8 -> imem_req stays 1 throughout; pc holds 8;
//   inst_valid pulses once, cycle after ack.
//  jump_en to 32'h0000_0103 while waiting at pc=C, ack 2 cycles later ->
//   word at C squashed; next pc=100.
//  jump_en (200) and branch_en (300) same cycle in IDLE -> pc=200; no squash.
//  stall=1 at ack of pc=10 -> state IDLE, pc=14, imem_req=0 until stall drops.
//  rst_n low mid-wait at pc=20 -> pc=RESET_PC immediately; req/valid 0;
//   late ack ignored. With PC_EXC_VECTOR_EN: exc_req at pc=40 -> pc=80, epc=40.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: issues fetches at pc, applies redirects,
// squashes wrong-path words. Optional exception vector support under `PC_EXC_VECTOR_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef PC_EXC_VECTOR_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
`ifdef PC_EXC_VECTOR_EN
  input  logic        exc_req,
  output logic [31:0] epc,
`endif
  output logic [31:0] inst,
  output logic        inst_valid
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        redirect_pending_q, redirect_pending_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic        redirect_now;
  logic [31:0] redirect_target;
  logic [31:0] next_pc;

  // Low target bits are discarded by alignment.
  logic unused_target_bits;
  assign unused_target_bits = ^{jump_target[1:0], branch_target[1:0]};

`ifdef PC_EXC_VECTOR_EN
  logic [31:0] epc_q, epc_d;

  assign redirect_now = exc_req | jump_en | branch_en;
  always_comb begin
    if (exc_req)      redirect_target = {EXC_VECTOR[31:2], 2'b00};
    else if (jump_en) redirect_target = {jump_target[31:2], 2'b00};
    else              redirect_target = {branch_target[31:2], 2'b00};
  end
  assign epc_d = exc_req ? pc_q : epc_q;
  assign epc   = epc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) epc_q <= 32'h0;
    else        epc_q <= epc_d;
  end
`else
  assign redirect_now    = jump_en | branch_en;
  assign redirect_target = jump_en ? {jump_target[31:2], 2'b00}
                                   : {branch_target[31:2], 2'b00};
`endif

  assign next_pc = redirect_now       ? redirect_target  :
                   redirect_pending_q ? pending_target_q : pc_plus4;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    inst_d             = inst_q;
    inst_valid_d       = 1'b0;
    redirect_pending_d = redirect_pending_q;
    pending_target_d   = pending_target_q;
    case (state_q)
      IDLE: begin
        // No fetch in flight, so a redirect simply moves the PC.
        if (redirect_now) pc_d = redirect_target;
        if (!stall)       state_d = REQ;
      end
      default: begin
        if (imem_ack) begin
          pc_d               = next_pc;
          inst_d             = imem_rdata;
          inst_valid_d       = !(redirect_now || redirect_pending_q);
          redirect_pending_d = 1'b0;
          state_d            = stall ? IDLE : REQ;
        end else if (redirect_now) begin
          redirect_pending_d = 1'b1;
          pending_target_d   = redirect_target;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      pc_q               <= RESET_PC;
      inst_q             <= 32'h0;
      inst_valid_q       <= 1'b0;
      redirect_pending_q <= 1'b0;
      pending_target_q   <= 32'h0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      inst_q             <= inst_d;
      inst_valid_q       <= inst_valid_d;
      redirect_pending_q <= redirect_pending_d;
      pending_target_q   <= pending_target_d;
    end
  end

  assign pc         = pc_q;
  assign imem_req   = (state_q == REQ);
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; the bench supplies the PC+4 adder and echoes pc as rdata.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump_en, branch_en, stall, imem_req, imem_ack, inst_valid;
  logic [31:0] jump_target, branch_target, imem_rdata, inst;
`ifdef PC_EXC_VECTOR_EN
  logic        exc_req;
  logic [31:0] epc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign pc_plus4   = pc + 32'd4;
  assign imem_rdata = pc;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4),
    .jump_en(jump_en), .jump_target(jump_target),
    .branch_en(branch_en), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
`ifdef PC_EXC_VECTOR_EN
    .exc_req(exc_req), .epc(epc),
`endif
    .inst(inst), .inst_valid(inst_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                         input logic e_valid, input logic [31:0] e_inst);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, e_req});
    chk({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, e_valid});
    chk({tag, ".inst"}, inst, e_inst);
    $display("step %-10s pc=%h req=%b valid=%b inst=%h", tag, pc, imem_req, inst_valid, inst);
  endtask

  initial begin
    rst_n = 1'b0; jump_en = 1'b0; branch_en = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0;
`ifdef PC_EXC_VECTOR_EN
    exc_req = 1'b0;
`endif
    tick(); tick();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0);

    rst_n = 1'b1;
    tick();
    chk_all("idle2req", 32'h0, 1'b1, 1'b0, 32'h0);

    imem_ack = 1'b1;
    tick(); chk_all("fetch0", 32'h4, 1'b1, 1'b1, 32'h0);
    tick(); chk_all("fetch4", 32'h8, 1'b1, 1'b1, 32'h4);

    // ack held off three cycles at pc=8
    imem_ack = 1'b0;
    tick(); chk_all("wait8a", 32'h8, 1'b1, 1'b0, 32'h4);
    tick(); chk_all("wait8b", 32'h8, 1'b1, 1'b0, 32'h4);
    tick(); chk_all("wait8c", 32'h8, 1'b1, 1'b0, 32'h4);
    imem_ack = 1'b1;
    tick(); chk_all("fetch8", 32'hC, 1'b1, 1'b1, 32'h8);
    imem_ack = 1'b0;
    tick(); chk_all("waitC", 32'hC, 1'b1, 1'b0, 32'h8);

    // jump while waiting at C: word at C is squashed
    jump_en = 1'b1; jump_target = 32'h0000_0103;
    tick(); chk_all("jmpwait", 32'hC, 1'b1, 1'b0, 32'h8);
    jump_en = 1'b0;
    tick(); chk_all("jmpwait2", 32'hC, 1'b1, 1'b0, 32'h8);
    imem_ack = 1'b1;
    tick(); chk_all("squashC", 32'h100, 1'b1, 1'b0, 32'hC);
    tick(); chk_all("fetch100", 32'h104, 1'b1, 1'b1, 32'h100);

    // same-cycle jump and ack
    jump_en = 1'b1; jump_target = 32'h0000_0010;
    tick(); chk_all("jmpack", 32'h10, 1'b1, 1'b0, 32'h104);
    jump_en = 1'b0;

    // stall at ack of pc=10 returns to IDLE
    stall = 1'b1;
    tick(); chk_all("stall10", 32'h14, 1'b0, 1'b1, 32'h10);
    imem_ack = 1'b0;
    tick(); chk_all("stallidle", 32'h14, 1'b0, 1'b0, 32'h10);

    // jump and branch together in IDLE: jump wins, nothing squashed
    jump_en = 1'b1; jump_target = 32'h200; branch_en = 1'b1; branch_target = 32'h300;
    tick(); chk_all("jmpbr", 32'h200, 1'b0, 1'b0, 32'h10);
    jump_en = 1'b0; branch_en = 1'b0; stall = 1'b0;
    tick(); chk_all("unstall", 32'h200, 1'b1, 1'b0, 32'h10);
    imem_ack = 1'b1;
    tick(); chk_all("fetch200", 32'h204, 1'b1, 1'b1, 32'h200);

    branch_en = 1'b1; branch_target = 32'h0000_0303;
    tick(); chk_all("branch", 32'h300, 1'b1, 1'b0, 32'h204);
    branch_en = 1'b0;
    jump_en = 1'b1; jump_target = 32'h20;
    tick(); chk_all("jmp20", 32'h20, 1'b1, 1'b0, 32'h300);
    jump_en = 1'b0; imem_ack = 1'b0;
    tick(); chk_all("wait20", 32'h20, 1'b1, 1'b0, 32'h300);

    // asynchronous reset mid-wait, then a late ack
    rst_n = 1'b0;
    #1;
    chk_all("asyncrst", 32'h0, 1'b0, 1'b0, 32'h0);
    imem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); chk_all("lateack", 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); chk_all("refetch0", 32'h4, 1'b1, 1'b1, 32'h0);

    // wrap-around through the top of the address space
    jump_en = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick(); chk_all("jmptop", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h4);
    jump_en = 1'b0;
    tick(); chk_all("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);

`ifdef PC_EXC_VECTOR_EN
    jump_en = 1'b1; jump_target = 32'h40;
    tick(); chk_all("jmp40", 32'h40, 1'b1, 1'b0, 32'h0);
    jump_en = 1'b0; exc_req = 1'b1;
    tick(); chk_all("exc", 32'h80, 1'b1, 1'b0, 32'h40);
    chk("exc.epc", epc, 32'h40);
    exc_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
